// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit and its skid buffer.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that absorbs a
// response arriving while IF/ID is stalled.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       unload,
  input  logic       flush,
  input  fetch_pkt_t d,
  output fetch_pkt_t q,
  output logic       valid
);

  fetch_pkt_t pkt_q, pkt_d;
  logic       valid_q, valid_d;

  always_comb begin
    pkt_d   = pkt_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pkt_d   = d;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
    end
  end

  assign q     = pkt_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM,
// IF/ID-facing output register with redirect squash.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        next_PC,
  output logic [31:0]        fetch_PC,
  output logic               if_valid
);

  fetch_state_e state_q, state_d;

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        fpc_q, fpc_d;
  logic               valid_q, valid_d;

  logic       resp, issue, advance, hold;
  logic       skid_valid, skid_load;
  logic       skid_unload, skid_flush;
  fetch_pkt_t skid_q, resp_pkt;

  assign resp    = (state_q == S_WAIT) & imem_rvalid;
  assign issue   = (state_q == S_REQ) & ~skid_valid &
                   ~redirect_valid;
  assign advance = ~redirect_valid & ~StallF;
  assign hold    = ~redirect_valid & StallF;
  assign resp_pkt = '{instr: imem_rdata, pc: req_pc_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  // A squash with data still in flight must eat it first.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (state_q != S_REQ && !imem_rvalid)
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end else begin
      unique case (state_q)
        S_REQ:   if (issue)       state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_d = S_REQ;
        S_DROP:  if (imem_rvalid) state_d = S_REQ;
        default:                  state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req  = reset & issue;
    imem_addr = pc_q;
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_target);
    end else if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + PC_INC;
    end
  end

  always_comb begin
    instr_d     = instr_q;
    fpc_d       = fpc_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;
    unique case (1'b1)
      redirect_valid: begin
        valid_d    = 1'b0;
        skid_flush = 1'b1;
      end
      hold: skid_load = resp;
      advance & skid_valid: begin
        instr_d     = skid_q.instr;
        fpc_d       = skid_q.pc;
        valid_d     = 1'b1;
        skid_unload = 1'b1;
      end
      advance & ~skid_valid & resp: begin
        instr_d = imem_rdata;
        fpc_d   = req_pc_q;
        valid_d = 1'b1;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      instr_q  <= NOP_INSTR;
      fpc_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      fpc_q    <= fpc_d;
      valid_q  <= valid_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .flush  (skid_flush),
    .d      (resp_pkt),
    .q      (skid_q),
    .valid  (skid_valid)
  );

  assign instruction = instr_q;
  assign fetch_PC    = fpc_q;
  assign if_valid    = valid_q;
  assign next_PC     = fpc_q + PC_INC;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency imem model plus
// a stream model of the expected fetch/presentation order.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int MIN_LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] next_PC;
  logic [31:0] fetch_PC;
  logic        if_valid;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .StallF          (StallF),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instruction     (instruction),
    .next_PC         (next_PC),
    .fetch_PC        (fetch_PC),
    .if_valid        (if_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int          lat_cfg  = 1;
  bit          lat_rand = 1'b0;
  bit          m_pend   = 1'b0;
  logic [31:0] m_addr;
  int          m_cnt;
  bit          m_req;
  logic [31:0] m_req_addr;

  logic [31:0] exp_req, exp_pc;
  bit          p_ok = 1'b0;
  bit          p_stall, p_redir;
  logic        p_valid;
  logic [31:0] p_instr, p_fpc;
  int          n_consumed = 0;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // Stream model: requests and consumed instructions walk
  // sequential PCs from the last reset/redirect target.
  task automatic mon_step();
    m_req      = imem_req;
    m_req_addr = imem_addr;
    if (!rst_n) begin
      exp_req = RESET_PC;
      exp_pc  = RESET_PC;
      p_ok    = 1'b0;
    end else begin
      if (imem_req) begin
        n_checks++;
        if (imem_addr !== exp_req)
          $display("FAIL mon_req_addr: got %h want %h",
                   imem_addr, exp_req);
        else n_pass++;
        exp_req = exp_req + 32'd4;
      end
      if (redirect_valid) begin
        n_checks++;
        if (imem_req !== 1'b0)
          $display("FAIL mon_req_in_redirect: got %b want 0",
                   imem_req);
        else n_pass++;
      end
      if (p_ok && p_stall && !p_redir) begin
        n_checks++;
        if ({if_valid, instruction, fetch_PC} !==
            {p_valid, p_instr, p_fpc})
          $display("FAIL mon_stall_hold: got %b/%h/%h want %b/%h/%h",
                   if_valid, instruction, fetch_PC,
                   p_valid, p_instr, p_fpc);
        else n_pass++;
      end
      if (p_ok && p_redir) begin
        n_checks++;
        if (if_valid !== 1'b0)
          $display("FAIL mon_redirect_bubble: got %b want 0",
                   if_valid);
        else n_pass++;
      end
      if (if_valid === 1'b1 && !StallF && !redirect_valid) begin
        n_checks++;
        if (fetch_PC !== exp_pc ||
            instruction !== mem_word(exp_pc) ||
            next_PC !== exp_pc + 32'd4)
          $display("FAIL mon_stream: got pc %h ins %h npc %h want pc %h ins %h npc %h",
                   fetch_PC, instruction, next_PC, exp_pc,
                   mem_word(exp_pc), exp_pc + 32'd4);
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (redirect_valid) begin
        exp_req = {redirect_target[31:2], 2'b00};
        exp_pc  = {redirect_target[31:2], 2'b00};
      end
      p_ok    = 1'b1;
      p_stall = StallF;
      p_redir = redirect_valid;
      p_valid = if_valid;
      p_instr = instruction;
      p_fpc   = fetch_PC;
    end
  endtask

  task automatic mem_step();
    imem_rvalid = 1'b0;
    if (m_req) begin
      n_checks++;
      if (m_pend)
        $display("FAIL mem_one_outstanding: got req %h while %h pending want none",
                 m_req_addr, m_addr);
      else n_pass++;
      m_pend = 1'b1;
      m_addr = m_req_addr;
      m_cnt  = lat_rand ? $urandom_range(MIN_LATENCY, 5)
                        : lat_cfg;
    end
    if (m_pend) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        m_pend      = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
    mem_step();
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst_n           = 1'b0;
    StallF          = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    lat_cfg         = lat;
    lat_rand        = 1'b0;
    repeat (8) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1);
    rst_n = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({if_valid, instruction, fetch_PC, imem_req} !== '0)
      $display("FAIL reset_outputs: got %b/%h/%h/%b want 0",
               if_valid, instruction, fetch_PC, imem_req);
    else n_pass++;
    n_checks++;
    if (next_PC !== 32'd4)
      $display("FAIL reset_next_pc: got %h want 4", next_PC);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL reset_first_req: got %b/%h want 1/%h",
               imem_req, imem_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_sequential();
    bit          e_req, e_val;
    logic [31:0] e_addr, e_fpc;
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      #1;
      e_req  = (i % 2 == 0);
      e_val  = (i % 2 == 0) && (i >= 2);
      e_addr = 32'(2 * i);
      e_fpc  = 32'(2 * i - 4);
      n_checks++;
      if (imem_req !== e_req || if_valid !== e_val)
        $display("FAIL seq_strobe[%0d]: got req %b val %b want %b %b",
                 i, imem_req, if_valid, e_req, e_val);
      else n_pass++;
      if (e_req) begin
        n_checks++;
        if (imem_addr !== e_addr)
          $display("FAIL seq_addr[%0d]: got %h want %h",
                   i, imem_addr, e_addr);
        else n_pass++;
      end
      if (e_val) begin
        n_checks++;
        if (fetch_PC !== e_fpc || next_PC !== e_fpc + 32'd4)
          $display("FAIL seq_out[%0d]: got %h/%h want %h/%h",
                   i, fetch_PC, next_PC, e_fpc, e_fpc + 32'd4);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic wait_out(input logic [31:0] pc,
                          output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (if_valid === 1'b1 && fetch_PC === pc) found = 1'b1;
      else tick();
    end
  endtask

  task automatic test_stall();
    bit found;
    do_reset(1);
    wait_out(32'h4, found);
    n_checks++;
    if (!found) $display("FAIL stall_reach_pc4: got timeout want pc 4");
    else n_pass++;
    StallF = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      n_checks++;
      if (imem_req !== (j == 0) ||
          (j == 0 && imem_addr !== 32'h8))
        $display("FAIL stall_req[%0d]: got %b/%h want %b/8",
                 j, imem_req, imem_addr, j == 0);
      else n_pass++;
      n_checks++;
      if (if_valid !== 1'b1 || fetch_PC !== 32'h4)
        $display("FAIL stall_hold[%0d]: got %b/%h want 1/4",
                 j, if_valid, fetch_PC);
      else n_pass++;
      tick();
    end
    StallF = 1'b0;
    tick();
    #1;
    n_checks++;
    if (if_valid !== 1'b1 || fetch_PC !== 32'h8 ||
        instruction !== mem_word(32'h8))
      $display("FAIL stall_skid_out: got %b/%h/%h want 1/8/%h",
               if_valid, fetch_PC, instruction, mem_word(32'h8));
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC)
      $display("FAIL stall_resume: got %b/%h want 1/c",
               imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_drop();
    bit found, seen_rv, got;
    do_reset(4);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      #1;
      if (imem_req && imem_addr === 32'h10) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found) $display("FAIL drop_reach_0x10: got timeout want req 10");
    else n_pass++;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    seen_rv = 1'b0;
    got     = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (imem_rvalid) seen_rv = 1'b1;
      if (imem_req) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got || !seen_rv || imem_addr !== 32'h100)
      $display("FAIL drop_next_req: got req %b rv_first %b addr %h want 1 1 100",
               got, seen_rv, imem_addr);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (if_valid === 1'b1) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found || fetch_PC !== 32'h100 ||
        instruction !== mem_word(32'h100))
      $display("FAIL drop_first_out: got %b/%h want 1/100",
               found, fetch_PC);
    else n_pass++;
  endtask

  task automatic test_redirect_rvalid();
    int n_rv;
    bit found;
    do_reset(1);
    n_rv = 0;
    for (int k = 0; k < 40 && n_rv < 2; k++) begin
      tick();
      if (imem_rvalid) n_rv++;
    end
    n_checks++;
    if (n_rv != 2) $display("FAIL rr_reach_rvalid: got %0d want 2", n_rv);
    else n_pass++;
    redirect_valid  = 1'b1;
    redirect_target = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 ||
        if_valid !== 1'b0)
      $display("FAIL rr_next_req: got %b/%h val %b want 1/200 val 0",
               imem_req, imem_addr, if_valid);
    else n_pass++;
    wait_out(32'h200, found);
    n_checks++;
    if (!found) $display("FAIL rr_first_out: got timeout want pc 200");
    else n_pass++;
  endtask

  task automatic test_redirect_stall();
    bit found;
    do_reset(1);
    wait_out(32'h4, found);
    StallF = 1'b1;
    repeat (3) tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    StallF         = 1'b0;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 ||
        imem_addr !== 32'h40)
      $display("FAIL rs_after: got val %b req %b addr %h want 0 1 40",
               if_valid, imem_req, imem_addr);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (if_valid === 1'b1) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found || fetch_PC !== 32'h40)
      $display("FAIL rs_first_out: got %b/%h want 1/40",
               found, fetch_PC);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit found;
    int n_rv;
    do_reset(4);
    wait_out(32'h0, found);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if_valid, instruction, fetch_PC, imem_req} !== '0)
      $display("FAIL ar_immediate: got %b/%h/%h/%b want 0",
               if_valid, instruction, fetch_PC, imem_req);
    else n_pass++;
    n_rv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (imem_rvalid) n_rv++;
    end
    n_checks++;
    if (n_rv != 1 || if_valid !== 1'b0 || instruction !== '0)
      $display("FAIL ar_late_resp: got rv %0d val %b ins %h want 1 0 0",
               n_rv, if_valid, instruction);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL ar_first_req: got %b/%h want 1/%h",
               imem_req, imem_addr, RESET_PC);
    else n_pass++;
    wait_out(RESET_PC, found);
    n_checks++;
    if (!found || instruction !== mem_word(RESET_PC))
      $display("FAIL ar_first_out: got %b/%h want 1/%h",
               found, instruction, mem_word(RESET_PC));
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] e_pc;
    int n;
    do_reset(1);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      #1;
      if (if_valid === 1'b1) begin
        e_pc = 32'hFFFF_FFF8 + 32'(4 * n);
        n_checks++;
        if (fetch_PC !== e_pc || next_PC !== e_pc + 32'd4)
          $display("FAIL wrap[%0d]: got %h/%h want %h/%h",
                   n, fetch_PC, next_PC, e_pc, e_pc + 32'd4);
        else n_pass++;
        n++;
      end
      tick();
    end
    n_checks++;
    if (n != 3) $display("FAIL wrap_count: got %0d want 3", n);
    else n_pass++;
  endtask

  task automatic test_random();
    int c0;
    do_reset(1);
    lat_rand = 1'b1;
    c0 = n_consumed;
    for (int k = 0; k < 3000; k++) begin
      StallF          = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 24) == 0);
      redirect_target = $urandom;
      tick();
    end
    StallF         = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) tick();
    lat_rand = 1'b0;
    n_checks++;
    if (n_consumed - c0 < 100)
      $display("FAIL rand_progress: got %0d want >=100",
               n_consumed - c0);
    else n_pass++;
  endtask

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_redirect_rvalid();
    test_redirect_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage producer that feeds the IF/ID pipeline register. It holds the PC and issues word fetches to a variable-latency instruction memory, one outstanding request at a time. It presents instruction, next_PC (PC+4) and a valid flag toward IF/ID, honours the fetch stall, and squashes in-flight fetches on a branch/jump redirect. `if_valid` low is a bubble, and the top level ORs its inverse into the IF/ID clr input.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- MIN_LATENCY, 1: minimum imem response latency in cycles. The bench only; the RTL must tolerate any latency ≥1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- StallF  in  1  fetch stall (IF/ID is holding); output register must hold
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  32  new PC; bits [1:0] treated as 0
- imem_req  out  1  one-cycle request strobe
- imem_addr  out  32  word address of request, valid with imem_req
- imem_rvalid  in  1  one-cycle response strobe
- imem_rdata  in  32  instruction, valid with imem_rvalid
- instruction  out  32  fetched instruction toward IF/ID
- next_PC  out  32  fetched PC + 4 toward IF/ID
- fetch_PC  out  32  PC of presented instruction
- if_valid  out  1  instruction/next_PC/fetch_PC are meaningful

Behaviour:
Registers:
- pc: next address to request.
- req_pc: address of the outstanding request.
- Output register: instruction, fetch_PC, if_valid.
- One-entry skid buffer: skid_instr, skid_pc, skid_valid.
- next_PC = fetch_PC + 4, combinational from the output register, mod 2^32.

Reset (async, any time, including with a request outstanding):
- state = S_REQ, pc = RESET_PC, all valids = 0, instruction = 0, fetch_PC = 0, imem_req = 0.
- A stale imem_rvalid arriving in S_REQ is ignored.

FSM (imem_req is combinational from state):
- S_REQ: if skid_valid=0 and redirect_valid=0, assert imem_req with imem_addr = pc. Then req_pc <= pc, pc <= pc+4 (wraps at 2^32), go to S_WAIT. Otherwise stay.
- S_WAIT: on imem_rvalid the response R = {imem_rdata, req_pc} is accepted and the FSM goes to S_REQ. Issue latency is therefore ≥2 cycles per instruction.
- S_DROP: on imem_rvalid discard the data and go to S_REQ.

Output update (evaluated every cycle):
1. redirect_valid=1 has highest priority, over StallF and over R:
   - if_valid <= 0, skid_valid <= 0, pc <= {redirect_target[31:2], 2'b00}.
   - From S_WAIT without rvalid this cycle: next state S_DROP. Otherwise next state S_REQ; any R this cycle is discarded.
   - No request is issued in a redirect cycle.
2. Else if StallF=0:
   - skid_valid=1: output <= skid, skid_valid <= 0.
   - Else if R present: output <= R, if_valid <= 1.
   - Else: if_valid <= 0 (bubble). instruction and fetch_PC hold their values.
3. Else (StallF=1): output holds. If R is present it is written into the skid buffer; the skid is always empty at that point because of the issue rule.

Invariants:
- At most one outstanding request.
- The skid buffer never overflows.
- No instruction is duplicated or lost without a redirect.
- The instruction sequence presented with if_valid=1 follows sequential PCs between redirects.

Simultaneous events:
- Redirect and rvalid in the same cycle: the response is dropped and the next state is S_REQ, not S_DROP.
- StallF and redirect together: the redirect wins.

Decomposition:
- Shared package `mips_pkg`:
  - fetch state enum {S_REQ, S_WAIT, S_DROP}
  - INSTR_W = 32, PC_INC = 4
  - NOP_INSTR = 32'h0
- One natural sub-module, `fetch_skid_buf`: a 1-entry buffer with load/unload/flush ports holding {instr, pc}.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset release, latency 1, StallF=0:
  - imem_addr sequence 0,4,8 with one imem_req every 2 cycles.
  - if_valid pulses carry fetch_PC 0,4,8 and next_PC 4,8,12.
  - Bubbles (if_valid=0) appear between instructions.
- StallF held 6 cycles while the response for PC 8 returns:
  - Output holds PC 4 throughout.
  - Skid captures PC 8 and no new imem_req is issued.
  - After StallF drops, PC 8 is presented next cycle, then fetching resumes at 12.
- Redirect to 0x100 while a request to 0x10 is outstanding with latency 4:
  - FSM goes to S_DROP and the 0x10 data is never presented.
  - Next imem_addr = 0x100; first valid fetch_PC = 0x100.
- Redirect_valid and imem_rvalid in the same cycle, target 0x203:
  - Response discarded, no S_DROP.
  - Next imem_addr = 0x200.
- Redirect while StallF=1 and skid full:
  - if_valid=0 and skid cleared next cycle.
  - Fetch restarts at the target.
- Async reset asserted mid-S_WAIT, then a late imem_rvalid:
  - Outputs go to 0 immediately and the late response is ignored.
  - First request after release is to RESET_PC.
